// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared CPU constants for the register file and its issue scoreboard.
//   NUM_REGS   : number of architectural registers
//   REG_ADDR_W : register address width
//   DATA_W     : register data width
//   REG_ZERO   : hard-wired zero register address
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One-hot decode of a register address into a busy-vector mask.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m       = {NUM_REGS{1'b0}};
        m[addr] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments while en is high and sticks at all-ones.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   en    : increment request for this cycle
//   count : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic         at_max_s;

    // Saturation detect.
    always_comb begin
        at_max_s = (count_r == {W{1'b1}});
    end

    // Count register; holds once all-ones is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (en && !at_max_s) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Tracks in-flight register writes and holds issue until every source and
// destination register of the presented instruction is free. Because the
// register file has a registered read with no write-to-read bypass, a bit
// cleared by writeback in cycle N only unblocks issue in cycle N+1.
// Ports:
//   clk, rst                     : clock; asynchronous active-high reset
//   iss_valid / iss_ready        : issue handshake (iss_ready combinational)
//   iss_rs, iss_rt (+ _used)     : source registers and whether they are read
//   iss_rd, iss_rd_write         : destination register and write enable
//   wb_valid, wb_reg             : writeback commit
//   flush                        : cancel all in-flight writes
//   busy_vec                     : registered per-register pending-write bits
//   outstanding                  : registered popcount of busy_vec
//   stall_count                  : registered saturating stall-cycle counter
//   err_spurious_wb              : registered sticky spurious-writeback flag
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_W     = 16,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    output logic                   iss_ready,
    input  logic [REG_ADDR_W-1:0]  iss_rs,
    input  logic [REG_ADDR_W-1:0]  iss_rt,
    input  logic                   iss_rs_used,
    input  logic                   iss_rt_used,
    input  logic [REG_ADDR_W-1:0]  iss_rd,
    input  logic                   iss_rd_write,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_reg,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [OUT_W-1:0]       outstanding,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   err_spurious_wb
);

    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] busy_r;
    logic [OUT_W-1:0]    outst_r;
    logic                err_r;

    logic                raw_rs_s;
    logic                raw_rt_s;
    logic                waw_s;
    logic                full_s;
    logic                ready_s;
    logic                accept_s;
    logic                set_s;
    logic                wb_act_s;
    logic                clr_s;
    logic                spur_s;
    logic                stall_s;
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [OUT_W-1:0]    outst_nxt_s;

    // Hazard detection and issue handshake; uses only registered busy state,
    // so a same-cycle writeback never unblocks the current cycle.
    always_comb begin
        raw_rs_s = iss_rs_used & busy_r[iss_rs];
        raw_rt_s = iss_rt_used & busy_r[iss_rt];
        waw_s    = iss_rd_write & busy_r[iss_rd];
        full_s   = (outst_r == OUT_MAX) & iss_rd_write & (iss_rd != REG_ZERO);
        ready_s  = ~flush & ~raw_rs_s & ~raw_rt_s & ~waw_s & ~full_s;
        accept_s = iss_valid & ready_s;
        stall_s  = iss_valid & ~ready_s & ~flush;
    end

    // Set/clear decode; writebacks to r0 are ignored entirely.
    always_comb begin
        set_s    = accept_s & iss_rd_write & (iss_rd != REG_ZERO);
        wb_act_s = wb_valid & ~flush & (wb_reg != REG_ZERO);
        clr_s    = wb_act_s & busy_r[wb_reg];
        spur_s   = wb_act_s & ~busy_r[wb_reg];
    end

    // Next busy vector and count; clear applied before set so set wins.
    always_comb begin
        busy_nxt_s  = busy_r;
        outst_nxt_s = outst_r;
        if (flush) begin
            busy_nxt_s  = {NUM_REGS{1'b0}};
            outst_nxt_s = {OUT_W{1'b0}};
        end else begin
            if (clr_s) begin
                busy_nxt_s = busy_nxt_s & ~reg_mask(wb_reg);
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (set_s) begin
                busy_nxt_s = busy_nxt_s | reg_mask(iss_rd);
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            outst_nxt_s = outst_r + OUT_W'(set_s) - OUT_W'(clr_s);
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= {NUM_REGS{1'b0}};
            outst_r <= {OUT_W{1'b0}};
        end else begin
            busy_r  <= busy_nxt_s;
            outst_r <= outst_nxt_s;
        end
    end

    // Sticky spurious-writeback flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (spur_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_s),
        .count (stall_count)
    );

    assign iss_ready       = ready_s;
    assign busy_vec        = busy_r;
    assign outstanding     = outst_r;
    assign err_spurious_wb = err_r;

endmodule
